// File: rtl/spr_linebuf_pp.sv
// spr_linebuf_pp: ping-pong sprite line buffer.
// One bank collects sprite pixels at a stepping horizontal counter while the
// other bank is read out (and cleared behind the read) at the display X.
// line_sync swaps the roles of the two banks.
// Optional build macro: SPR_LB_PRIORITY_EN -- when defined, overlapping opaque
// pixels resolve by priority (first opaque wins, pri=1 beats pri=0); when
// undefined, the last opaque write wins.
module spr_linebuf_pp #(
  parameter int PLANES = 3,
  parameter int COLW   = 5,
  parameter int XW     = 9
) (
  input  logic                   pixel_clk,
  input  logic                   SPR_ROM_ADDR_RST,
  input  logic                   line_sync,
  input  logic                   flip,
  input  logic                   ld,
  input  logic [XW-1:0]          hpos,
  input  logic [COLW-1:0]        attr,
  input  logic                   pri,
  input  logic                   pix_vld,
  input  logic [PLANES-1:0]      planes,
  input  logic                   rd_en,
  input  logic [XW-1:0]          rd_x,
  output logic [COLW+PLANES-1:0] pix_out,
  output logic                   pri_out,
  output logic                   bank
);

  localparam int W     = COLW + PLANES + 1;
  localparam int DEPTH = 1 << XW;

  typedef logic [W-1:0] word_t;

  word_t           mem_a [DEPTH];
  word_t           mem_b [DEPTH];

  logic [XW-1:0]   wcnt;
  logic [COLW-1:0] attr_q;
  logic            pri_q;

  logic [XW-1:0]   wr_base;
  logic [XW-1:0]   wcnt_nxt;
  word_t           wr_data;
  logic            opaque;
  logic            wr_en;
  logic            rd_clr;
  word_t           rd_word;

  // A load restarts the walk at hpos; the counter always points one past the
  // pixel just written, in the direction selected by flip (modulo 2**XW).
  assign wr_base  = ld ? hpos : wcnt;
  assign wcnt_nxt = flip ? (wr_base + XW'(1)) : (wr_base - XW'(1));
  assign wr_data  = ld ? {pri, attr, planes} : {pri_q, attr_q, planes};
  assign opaque   = pix_vld && (planes != '0);
  assign rd_word  = bank ? mem_a[rd_x] : mem_b[rd_x];

`ifdef SPR_LB_PRIORITY_EN
  logic              old_pri;
  logic [PLANES-1:0] old_planes;
  logic              wr_block;

  // Peek at the current write-bank word so an opaque pixel already there is
  // kept unless the new pixel has priority over it.
  assign old_pri    = bank ? mem_b[wr_base][W-1] : mem_a[wr_base][W-1];
  assign old_planes = bank ? mem_b[wr_base][PLANES-1:0] : mem_a[wr_base][PLANES-1:0];
  assign wr_block   = (old_planes != '0) && (old_pri || !wr_data[W-1]);
  assign wr_en      = opaque && !wr_block && !SPR_ROM_ADDR_RST;
`else
  assign wr_en      = opaque && !SPR_ROM_ADDR_RST;
`endif

  assign rd_clr = rd_en && !SPR_ROM_ADDR_RST;

  // Storage: write into the write bank, clear the read bank behind the display.
  // NOTE: the line memories have no reset branch; resetting thousands of words
  // is neither needed (reading clears them) nor mappable onto RAM macros.
  always_ff @(posedge pixel_clk) begin
    if (!bank) begin
      if (wr_en)  mem_a[wr_base] <= wr_data;
      if (rd_clr) mem_b[rd_x]    <= '0;
    end else begin
      if (wr_en)  mem_b[wr_base] <= wr_data;
      if (rd_clr) mem_a[rd_x]    <= '0;
    end
  end

  // Control state: bank select, write counter, latched sprite attributes and
  // the registered output pixel.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // this is what makes line_sync apply only after the same-cycle write/read.
  always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
    if (SPR_ROM_ADDR_RST) begin
      bank    <= 1'b0;
      wcnt    <= '0;
      attr_q  <= '0;
      pri_q   <= 1'b0;
      pix_out <= '0;
      pri_out <= 1'b0;
    end else begin
      if (line_sync) bank <= ~bank;

      if (ld) begin
        wcnt   <= wcnt_nxt;
        attr_q <= attr;
        pri_q  <= pri;
      end else if (pix_vld) begin
        wcnt   <= wcnt_nxt;
      end

      if (rd_en) begin
        pix_out <= rd_word[W-2:0];
        pri_out <= rd_word[W-1];
      end else begin
        pix_out <= '0;
        pri_out <= 1'b0;
      end
    end
  end

endmodule
